regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core. It generalises the single-write, two-read flop array to NR read ports and NW write ports, with a hardwired-zero r0 and a per-register busy scoreboard for hazard detection. Decode reads operands and reserves destinations here; writeback ports write results and release reservations.

Parameters:
N, 32, number of registers (power of two, >=2); AW = $clog2(N)
W, 32, register width in bits
NR, 2, number of read ports (>=1)
NW, 2, number of write ports (>=1); a higher index has higher priority
ZERO_REG, 1, 1 = r0 reads 0, ignores writes, never busy; 0 = r0 is an ordinary register

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
wen  in  NW  per-port write enable
waddr  in  NW x AW  per-port write address
wdata  in  NW x W  per-port write data
raddr  in  NR x AW  per-port read address
rdata  out  NR x W  per-port read data (combinational)
rd_busy  out  NR  register at raddr[i] has a pending reservation
rsv_en  in  1  reserve destination register (decode issue)
rsv_addr  in  AW  register to reserve
busy_vec  out  N  full scoreboard state
wr_conflict  out  1  registered pulse: two or more enabled write ports targeted the same address in the previous cycle

Behaviour:
- Reset (async assert, released synchronously by the integrator): all registers = 0, busy_vec = 0, wr_conflict = 0. Reset mid-operation discards pending writes and reservations.
- Write: at posedge, each port j with wen[j] writes wdata[j] to regs[waddr[j]]. If several ports hit the same address, the highest-index port wins, and wr_conflict = 1 on the following cycle (otherwise 0).
- ZERO_REG=1: writes to address 0 are dropped and do not count toward wr_conflict. rdata for raddr 0 is 0. busy_vec[0] is always 0.
- Scoreboard, evaluated at posedge:
  - Any enabled write to address a clears busy[a].
  - rsv_en sets busy[rsv_addr].
  - If rsv_en and a write target the same address in the same cycle, the reservation wins and busy stays 1, because the issuing instruction is a newer producer.
  - Reserving an already-busy register is legal; it stays 1.
- Read: rdata[i] = regs[raddr[i]] and rd_busy[i] = busy[raddr[i]], both combinational with zero-cycle latency.
- Register state changes are visible on rdata the cycle after the write edge (unless bypass is enabled).
- Read ports are independent. Any number of ports may read the same address.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: if any wen[j] matches raddr[i] in the same cycle (excluding r0 when ZERO_REG=1), rdata[i] = wdata of the highest-index matching port, and rd_busy[i] = 0 unless rsv_en && rsv_addr == raddr[i].
- Undefined: no forwarding. Reads return the pre-edge array value, and rd_busy reflects only the registered busy bit.

Decomposition:
- Package regfile_pkg:
  - function addr_w(N) returning $clog2(N)
  - parameterised typedefs reg_addr_t and reg_data_t
  - localparam ZERO_ADDR = '0
- Sub-module regfile_scoreboard: holds the N-bit busy vector and implements the set/clear/priority rules. Inputs are wen, waddr, rsv_en and rsv_addr. Output is busy_vec.
- The data array, bypass muxes and conflict detection stay in regfile_mp.

Test Plan:
- Reset and r0: assert rst mid-run, then write 0xDEADBEEF to r5 and r0 -> after the edge, rdata(r5)=0xDEADBEEF; rdata(r0)=0; busy_vec=0.
- Write priority: wen=2'b11, waddr={7,7}, wdata={0x22,0x11} -> r7=0x22 (port 1 wins); wr_conflict=1 for exactly one cycle.
- Scoreboard set/clear: reserve r3 -> rd_busy=1 while reading r3. Port 0 writes r3=0x55 -> busy[3]=0 next cycle and rdata=0x55.
- Reserve/write collision: rsv_en on r9 and write r9=0xA5 in the same cycle -> busy[9]=1 and r9=0xA5.
- Bypass: write r12=0x1234 while reading r12 on both ports, with r12 previously 0 -> with REGFILE_BYPASS_EN both rdata=0x1234 in the same cycle; without it, 0 that cycle and 0x1234 the next.
- Parameter sweep: N=16, W=64, NR=4, NW=1, ZERO_REG=0 -> write r0=0xFFFF_FFFF_0000_0001; all four ports read it back correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Provides the address-width helper, default-sized address/data typedefs
// and the hardwired-zero register index.
package regfile_pkg;

   localparam int unsigned DEF_N = 32;
   localparam int unsigned DEF_W = 32;

   // Address width for an N-entry register file.
   function automatic int unsigned addr_w(input int unsigned n);
      return $clog2(n);
   endfunction

   typedef logic [addr_w(DEF_N)-1:0] reg_addr_t;
   typedef logic [DEF_W-1:0]         reg_data_t;

   localparam int unsigned ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: writes release, reservations set (reservation wins).
// Latency: state updates at posedge, busy_vec is the registered state.
// Backpressure: none, every write and reservation is accepted each cycle.
//
// Ports: clk, rst (async active-high) | wen/waddr per write port |
//        rsv_en/rsv_addr reservation request | busy_vec full scoreboard state.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int N        = 32,
   parameter int NW       = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = addr_w(N)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NW-1:0]          wen,
   input  logic [NW-1:0][AW-1:0]  waddr,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr,
   output logic [N-1:0]           busy_vec
);

   localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

   logic [N-1:0] busy_q;
   logic [N-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NW; j++) begin
         if (wen[j]) busy_d[waddr[j]] = 1'b0;
      end
      // Applied after the clears: the issuing instruction is the newer producer.
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
      if (ZERO_REG != 0) busy_d[ZA] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero r0, busy scoreboard and conflict flag.
// Latency: reads combinational; writes visible the cycle after the edge (same cycle with bypass).
// Backpressure: none, all ports are serviced every cycle.
//
// Ports: clk, rst (async active-high) | wen/waddr/wdata per write port (higher index wins) |
//        raddr -> rdata/rd_busy per read port | rsv_en/rsv_addr reservation |
//        busy_vec scoreboard | wr_conflict registered same-address write pulse.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int N        = 32,
   parameter int W        = 32,
   parameter int NR       = 2,
   parameter int NW       = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = addr_w(N)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NW-1:0]          wen,
   input  logic [NW-1:0][AW-1:0]  waddr,
   input  logic [NW-1:0][W-1:0]   wdata,
   input  logic [NR-1:0][AW-1:0]  raddr,
   output logic [NR-1:0][W-1:0]   rdata,
   output logic [NR-1:0]          rd_busy,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr,
   output logic [N-1:0]           busy_vec,
   output logic                   wr_conflict
);

   localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);

   logic [N-1:0][W-1:0] regs_q;
   logic [N-1:0][W-1:0] regs_d;
   logic                conflict_q;
   logic                conflict_d;
   logic [NW-1:0]       wv;   // write port effective (r0 writes dropped when hardwired)

   always_comb begin
      for (int j = 0; j < NW; j++) begin
         wv[j] = wen[j] && !((ZERO_REG != 0) && (waddr[j] == ZA));
      end
   end

   // Ascending port order makes the highest-index port the final writer.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NW; j++) begin
         if (wv[j]) regs_d[waddr[j]] = wdata[j];
      end
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int j = 0; j < NW; j++) begin
         for (int k = j + 1; k < NW; k++) begin
            if (wv[j] && wv[k] && (waddr[j] == waddr[k])) conflict_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         conflict_q <= conflict_d;
      end
   end

   assign wr_conflict = conflict_q;

   regfile_scoreboard #(
      .N        (N),
      .NW       (NW),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen),
      .waddr    (waddr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         rdata[i]   = regs_q[raddr[i]];
         rd_busy[i] = busy_vec[raddr[i]];
`ifdef REGFILE_BYPASS_EN
         // A forwarded value has just been produced, so it is only busy if
         // decode is re-reserving the same register this cycle.
         for (int j = 0; j < NW; j++) begin
            if (wv[j] && (waddr[j] == raddr[i])) begin
               rdata[i]   = wdata[j];
               rd_busy[i] = rsv_en && (rsv_addr == raddr[i]);
            end
         end
`endif
         if ((ZERO_REG != 0) && (raddr[i] == ZA)) rdata[i] = '0;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int N  = 32;
   localparam int W  = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int ZR = 1;
   localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] BYP_EXP = 32'h1234;
`else
   localparam logic [31:0] BYP_EXP = 32'h0;
`endif

   logic                  clk;
   logic                  rst;
   logic [NW-1:0]         wen;
   logic [NW-1:0][AW-1:0] waddr;
   logic [NW-1:0][W-1:0]  wdata;
   logic [NR-1:0][AW-1:0] raddr;
   logic [NR-1:0][W-1:0]  rdata;
   logic [NR-1:0]         rd_busy;
   logic                  rsv_en;
   reg_addr_t             rsv_addr;
   logic [N-1:0]          busy_vec;
   logic                  wr_conflict;

   // Second instance: parameter sweep with ordinary r0.
   logic [0:0]            wen2;
   logic [0:0][3:0]       waddr2;
   logic [0:0][63:0]      wdata2;
   logic [3:0][3:0]       raddr2;
   logic [3:0][63:0]      rdata2;
   logic [3:0]            rd_busy2;
   logic                  rsv_en2;
   logic [3:0]            rsv_addr2;
   logic [15:0]           busy_vec2;
   logic                  wr_conflict2;

   regfile_mp #(.N(N), .W(W), .NR(NR), .NW(NW), .ZERO_REG(ZR)) dut (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr), .busy_vec(busy_vec), .wr_conflict(wr_conflict)
   );

   regfile_mp #(.N(16), .W(64), .NR(4), .NW(1), .ZERO_REG(0)) dut2 (
      .clk(clk), .rst(rst), .wen(wen2), .waddr(waddr2), .wdata(wdata2),
      .raddr(raddr2), .rdata(rdata2), .rd_busy(rd_busy2), .rsv_en(rsv_en2),
      .rsv_addr(rsv_addr2), .busy_vec(busy_vec2), .wr_conflict(wr_conflict2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] mregs [N];
   logic         mbusy [N];
   logic         mconf;
   int           cnt [N];

   initial begin
      for (int a = 0; a < N; a++) begin
         mregs[a] = '0;
         mbusy[a] = 1'b0;
      end
      mconf = 1'b0;
   end

   function automatic logic wr_ok(input int j);
      return wen[j] && !(ZR != 0 && waddr[j] == 0);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < N; a++) begin
            mregs[a] = '0;
            mbusy[a] = 1'b0;
         end
         mconf = 1'b0;
      end else begin
         for (int a = 0; a < N; a++) cnt[a] = 0;
         for (int j = 0; j < NW; j++) begin
            if (wr_ok(j)) begin
               mregs[waddr[j]] = wdata[j];
               cnt[waddr[j]]   = cnt[waddr[j]] + 1;
            end
         end
         mconf = 1'b0;
         for (int a = 0; a < N; a++) if (cnt[a] > 1) mconf = 1'b1;
         for (int j = 0; j < NW; j++) if (wen[j]) mbusy[waddr[j]] = 1'b0;
         if (rsv_en) mbusy[rsv_addr] = 1'b1;
         if (ZR != 0) mbusy[0] = 1'b0;
      end
   end

   function automatic logic fwd_hit(input int i);
      logic hit;
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NW; j++) if (wr_ok(j) && waddr[j] == raddr[i]) hit = 1'b1;
`endif
      return hit;
   endfunction

   function automatic logic [W-1:0] exp_rd(input int i);
      logic [W-1:0] v;
      v = mregs[raddr[i]];
      if (fwd_hit(i)) begin
         for (int j = 0; j < NW; j++) if (wr_ok(j) && waddr[j] == raddr[i]) v = wdata[j];
      end
      if (ZR != 0 && raddr[i] == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_busy(input int i);
      if (fwd_hit(i)) return rsv_en && (rsv_addr == raddr[i]);
      return mbusy[raddr[i]];
   endfunction

   // Compare process: all outputs of the main instance against the model every cycle.
   always @(negedge clk) begin
      logic [N-1:0] ev;
      for (int a = 0; a < N; a++) ev[a] = mbusy[a];
      for (int i = 0; i < NR; i++) begin
         chk($sformatf("rdata[%0d]@r%0d", i, raddr[i]), rdata[i], exp_rd(i));
         chk($sformatf("rd_busy[%0d]@r%0d", i, raddr[i]), rd_busy[i], exp_busy(i));
      end
      chk("busy_vec", busy_vec, ev);
      chk("wr_conflict", wr_conflict, mconf);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen = '0; rsv_en = 1'b0; wen2 = '0; rsv_en2 = 1'b0;
   endtask

   task automatic rand_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         step();
         for (int j = 0; j < NW; j++) begin
            wen[j]   = ($urandom_range(0, 3) != 0);
            waddr[j] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3))
                                                   : AW'($urandom_range(0, N - 1));
            wdata[j] = $urandom;
         end
         for (int i = 0; i < NR; i++) begin
            raddr[i] = ($urandom_range(0, 2) == 0) ? waddr[$urandom_range(0, NW - 1)]
                                                   : AW'($urandom_range(0, N - 1));
         end
         rsv_en   = ($urandom_range(0, 1) != 0);
         rsv_addr = ($urandom_range(0, 1) != 0) ? waddr[0] : AW'($urandom_range(0, N - 1));
      end
   endtask

   initial begin
      rst = 1'b1;
      wen = '0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
      wen2 = '0; waddr2 = '0; wdata2 = '0; raddr2 = '0; rsv_en2 = 1'b0; rsv_addr2 = '0;

      @(negedge clk);
      @(negedge clk);
      chk("reset_busy_vec", busy_vec, 0);
      chk("reset_wr_conflict", wr_conflict, 0);
      chk("reset_busy_vec2", busy_vec2, 0);
      step();
      rst = 1'b0;

      rand_cycles(300);

      // Asynchronous reset in the middle of random traffic.
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("midreset_busy_vec", busy_vec, 0);
      chk("midreset_wr_conflict", wr_conflict, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // r5 and r0 writes after reset; sweep instance writes its ordinary r0.
      idle();
      wen = 2'b11;
      waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
      waddr[1] = 5'd0; wdata[1] = 32'h12345678;
      raddr[0] = 5'd5; raddr[1] = 5'd0;
      wen2 = 1'b1; waddr2[0] = 4'd0; wdata2[0] = 64'hFFFF_FFFF_0000_0001;
      raddr2 = '0;
      step();
      idle();
      @(negedge clk);
      chk("r5_after_reset", rdata[0], 32'hDEADBEEF);
      chk("r0_reads_zero", rdata[1], 32'h0);
      chk("busy_after_reset", busy_vec, 0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("sweep_rdata[%0d]", i), rdata2[i], 64'hFFFF_FFFF_0000_0001);

      // Same-address write: port 1 wins, conflict pulses once.
      step();
      wen = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
      wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[0] = 5'd7;
      step();
      wen = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
      @(negedge clk);
      chk("r7_priority", rdata[0], 32'h22);
      chk("conflict_pulse", wr_conflict, 1);
      step();
      idle();
      @(negedge clk);
      chk("conflict_cleared", wr_conflict, 0);
      step();
      @(negedge clk);
      chk("r0_no_conflict", wr_conflict, 0);

      // Reserve r3, then release it with a write.
      rsv_en = 1'b1; rsv_addr = 5'd3; raddr[0] = 5'd3;
      rsv_en2 = 1'b1; rsv_addr2 = 4'd0;
      step();
      idle();
      @(negedge clk);
      chk("r3_rd_busy", rd_busy[0], 1);
      chk("r3_busy_vec", busy_vec[3], 1);
      chk("sweep_r0_busy", busy_vec2[0], 1);
      step();
      wen = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h55;
      step();
      idle();
      @(negedge clk);
      chk("r3_released", rd_busy[0], 0);
      chk("r3_data", rdata[0], 32'h55);

      // Reservation and write to r9 in the same cycle.
      step();
      rsv_en = 1'b1; rsv_addr = 5'd9;
      wen = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'hA5; raddr[0] = 5'd9;
      step();
      idle();
      @(negedge clk);
      chk("r9_busy_kept", busy_vec[9], 1);
      chk("r9_data", rdata[0], 32'hA5);

      // Read r12 on both ports while it is written.
      step();
      wen = 2'b01; waddr[0] = 5'd12; wdata[0] = 32'h1234;
      raddr[0] = 5'd12; raddr[1] = 5'd12;
      @(negedge clk);
      chk("r12_same_cycle_p0", rdata[0], BYP_EXP);
      chk("r12_same_cycle_p1", rdata[1], BYP_EXP);
      step();
      idle();
      @(negedge clk);
      chk("r12_next_p0", rdata[0], 32'h1234);
      chk("r12_next_p1", rdata[1], 32'h1234);

      rand_cycles(400);
      step();
      idle();
      @(negedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
